stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//  Control stage directly upstream of the two-digit BCD seconds counter.
//  Debounces the raw Start/Stop and Clear buttons and runs an IDLE/RUN/PAUSE FSM.
//  Produces a one-cycle Enable tick at TICK_HZ while running, and a one-cycle ClearCount pulse.
//  The counter's Enable input takes Enable; its active-high sync Reset takes ClearCount.
// PARAMETERS
//  CLK_HZ           50_000_000  system clock frequency
//  TICK_HZ          1           Enable tick rate; DIV = CLK_HZ/TICK_HZ (integer, >=2)
//  DEBOUNCE_CYCLES  1_000_000   consecutive stable cycles needed to accept a level (>=1)
// PORTS
//  Clock       in   1  system clock, rising edge
//  Reset       in   1  asynchronous, active-low reset
//  StartStop   in   1  raw button, active-high, asynchronous to Clock
//  Clear       in   1  raw button, active-high, asynchronous to Clock
//  Enable      out  1  one-cycle count tick, registered
//  ClearCount  out  1  one-cycle counter-clear pulse, registered
//  Running     out  1  high while FSM is in RUN, registered
// BEHAVIOUR
//  Reset low: FSM=IDLE; prescaler, debounce counters and sync flops cleared.
//   Debounced levels reset to 0. Enable, ClearCount and Running are all 0.
//  Button path, per button:
//   - 2-FF synchroniser.
//   - Debounce counter, width $clog2(DEBOUNCE_CYCLES+1):
//     zeroed whenever the synced value equals the debounced level;
//     otherwise increments. At DEBOUNCE_CYCLES the debounced level flips and the counter zeroes.
//   - A 0->1 transition of the debounced level gives a one-cycle press pulse.
//   - A button held through reset release registers as one press once debounced.
//  FSM transitions (evaluated on press pulses):
//   IDLE : start -> RUN; clear -> IDLE, ClearCount pulse.
//   RUN  : start -> PAUSE; clear ignored.
//   PAUSE: start -> RUN; clear -> IDLE, ClearCount pulse.
//   Start and clear in the same cycle: in IDLE/PAUSE clear wins; in RUN start wins.
//  Prescaler: width $clog2(DIV). Counts only in RUN.
//   - On an edge in RUN with count==DIV-1: count<=0, Enable<=1. Any other edge: Enable<=0.
//   - First Enable is high in the cycle after the DIV-th edge following RUN entry.
//   - PAUSE holds the count, so the partial period is kept; entering IDLE zeroes it.
//   - A pause press on the same edge as a wrap still emits that tick.
//  Enable is never high for two consecutive cycles and never high outside RUN+1 cycle.
//  ClearCount is high exactly one cycle, on the edge after the FSM enters IDLE via clear.
//  Running is registered from the next-state value, so it is high in the same cycle as RUN.
//  Reset asserted mid-count: immediate return to reset values, no Enable/ClearCount glitch.
// STRUCTURE
//  stopwatch_pkg: FSM state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2)
//   and a DIV derivation function shared with the bench.
//  Sub-module btn_debounce (sync + debounce + rising-edge pulse, param DEBOUNCE_CYCLES),
//   instantiated twice. FSM and prescaler stay in stopwatch_ctrl.
// TESTING  (bench params: CLK_HZ=100, TICK_HZ=10 -> DIV=10, DEBOUNCE_CYCLES=4)
//  1. Reset low 3 cycles, buttons 0 -> all outputs 0; Running 0 for 50 cycles, no Enable.
//  2. StartStop high 10 cycles -> Running rises ~7 cycles after the press.
//     Enable then pulses every 10 cycles; 5 ticks are seen in 50 cycles.
//  3. StartStop bounces 1-0-1-0 at 1-cycle spacing, then stays low -> no press, state unchanged.
//  4. RUN 14 cycles past a tick, pause, wait 100, resume -> next Enable 6 cycles after resume.
//  5. In PAUSE, press Clear -> one ClearCount pulse and IDLE. In RUN, Clear -> no ClearCount.
//  6. Start+Clear pressed together in PAUSE -> IDLE + ClearCount.
//     Reset low mid-period -> Enable 0, count restarts at a full 10 cycles.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encodings and the prescaler divide-ratio helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-FF synchroniser, stable-count debounce, and a
// one-cycle registered pulse on each accepted 0->1 transition.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Button,
  output logic Press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt + CW'(1);

  // Level flips only after DEBOUNCE_CYCLES consecutive cycles disagreeing with it.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      Press <= 1'b0;
    end else begin
      sync1 <= Button;
      sync2 <= sync1;
      Press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
        level <= ~level;
        cnt   <= '0;
        Press <= ~level;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced Start/Stop and Clear drive an IDLE/RUN/PAUSE FSM
// that gates a prescaler producing the counter's Enable tick and ClearCount pulse.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned TICK_HZ         = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic StartStop,
  input  logic Clear,
  output logic Enable,
  output logic ClearCount,
  output logic Running
);

  localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int unsigned PW  = $clog2(DIV);

  state_t        state;
  state_t        state_nxt;
  logic          clear_nxt;
  logic          start_press;
  logic          clr_press;
  logic [PW-1:0] pcount;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .Clock  (Clock),
    .Reset  (Reset),
    .Button (StartStop),
    .Press  (start_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .Clock  (Clock),
    .Reset  (Reset),
    .Button (Clear),
    .Press  (clr_press)
  );

  // Next state; clear outranks start except in RUN, where clear is ignored.
  always_comb begin
    state_nxt = state;
    clear_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clr_press) begin
          clear_nxt = 1'b1;
        end else if (start_press) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (start_press) begin
          state_nxt = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (clr_press) begin
          state_nxt = ST_IDLE;
          clear_nxt = 1'b1;
        end else if (start_press) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, prescaler and registered outputs; PAUSE holds the partial period.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= ST_IDLE;
      pcount     <= '0;
      Enable     <= 1'b0;
      ClearCount <= 1'b0;
      Running    <= 1'b0;
    end else begin
      state      <= state_nxt;
      Running    <= (state_nxt == ST_RUN);
      ClearCount <= clear_nxt;
      Enable     <= 1'b0;
      if (state == ST_RUN) begin
        if (pcount == PW'(DIV - 1)) begin
          pcount <= '0;
          Enable <= 1'b1;
        end else begin
          pcount <= pcount + PW'(1);
        end
      end else if (state_nxt == ST_IDLE) begin
        pcount <= '0;
      end
    end
  end

endmodule
